fft_pipe_ctrl: RTL

- Sequencer for the radix-2^2 single-path delay-feedback FFT pipeline built from the BF2I and BF2II stage blocks.
- Counts samples within a frame and drives the butterfly select bits, the twiddle ROM address and one global shift-register enable to every stage.
- Tracks samples in flight so output valid, first and last flags line up with the last stage's registered output.
- Pads incomplete frames with zeros and drains the pipeline when input stops.

---
 rtl/fft_pipe_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fft_pipe_ctrl.sv
// fft_pipe_ctrl
// Sequencer for a radix-2^2 single-path delay-feedback FFT pipeline built from
// BF2I / BF2II stages. It counts samples within a frame, drives the butterfly
// select bits (s_ctrl), the twiddle ROM address and the single shift-register
// enable shared by every stage. It also tracks samples in flight so that the
// output flags line up with the last stage's registered output. Incomplete
// frames are zero-padded, and the pipeline is drained when input stops.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      upstream presents a sample this cycle
//   in_ready      controller accepts the sample (accept = in_valid & in_ready)
//   zero_in       input mux selects zero instead of upstream data
//   enable        global enable to every stage shift register
//   s_ctrl        sample index within the current input frame
//   twiddle_addr  s_ctrl delayed through the multiplier-stage depth
//   out_valid     last-stage output carries a real or padded frame sample
//   out_first     out_valid and the output is bin 0
//   out_last      out_valid and the output is bin N-1
//   busy          controller is not idle
//   frame_err     sticky flag, set when a frame was zero-padded
module fft_pipe_ctrl #(
  parameter int log2_n       = 6,
  parameter int pipe_latency = 69
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              zero_in,
  output logic              enable,
  output logic [log2_n-1:0] s_ctrl,
  output logic [log2_n-1:0] twiddle_addr,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err
);

  localparam int n_pts    = 1 << log2_n;
  localparam int tw_depth = n_pts / 4 + 1;
  localparam int flight_w = $clog2(pipe_latency + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [log2_n-1:0]   idx_first   = '0;
  localparam logic [log2_n-1:0]   idx_last    = '1;
  localparam logic [log2_n-1:0]   idx_one     = {{(log2_n-1){1'b0}}, 1'b1};
  localparam logic [flight_w-1:0] flight_zero = '0;
  localparam logic [flight_w-1:0] flight_one  = {{(flight_w-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [flight_w-1:0] flight;
  logic                accept;
  logic                pad;
  logic                insert;
  logic                set_err;
  logic                drain_done;

  // Each entry is {valid, first, last}; the tail lines up with the last stage.
  logic [2:0]          vline   [pipe_latency];
  logic [2:0]          tail;
  logic [log2_n-1:0]   tw_line [tw_depth];

  assign tail         = vline[pipe_latency-1];
  assign insert       = accept | pad;
  assign out_valid    = enable & tail[2];
  assign out_first    = enable & tail[1];
  assign out_last     = enable & tail[0];
  assign busy         = (state != IDLE);
  assign twiddle_addr = tw_line[tw_depth-1];

  // In DRAIN nothing is inserted, so the pipe is empty after this edge when
  // the only sample left (if any) is leaving right now.
  assign drain_done = (flight == flight_zero) || ((flight == flight_one) && tail[2]);

  // Next-state and handshake decode. Everything is forced low while reset is
  // held so no stage moves and no sample is accepted during reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    zero_in    = 1'b0;
    enable     = 1'b0;
    accept     = 1'b0;
    pad        = 1'b0;
    set_err    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          enable   = in_valid;
          accept   = in_valid;
          if (in_valid) state_next = RUN;
        end
        RUN: begin
          in_ready = 1'b1;
          enable   = 1'b1;
          zero_in  = !in_valid;
          if (in_valid) begin
            accept = 1'b1;
          end else if (s_ctrl != idx_first) begin
            // The first pad sample goes in this same cycle; if it already
            // completes the frame there is nothing left to pad.
            pad        = 1'b1;
            set_err    = 1'b1;
            state_next = (s_ctrl == idx_last) ? DRAIN : PAD;
          end else begin
            state_next = DRAIN;
          end
        end
        PAD: begin
          enable  = 1'b1;
          zero_in = 1'b1;
          pad     = 1'b1;
          if (s_ctrl == idx_last) state_next = DRAIN;
        end
        default: begin
          // DRAIN: pipeline keeps running on zeros; a new sample restarts a
          // frame (s_ctrl is 0 here) and wins over going idle.
          in_ready = 1'b1;
          enable   = 1'b1;
          zero_in  = !in_valid;
          if (in_valid) begin
            accept     = 1'b1;
            state_next = RUN;
          end else if (drain_done) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  // State, frame counter, sticky error and in-flight bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      s_ctrl    <= '0;
      frame_err <= 1'b0;
      flight    <= '0;
    end else begin
      state <= state_next;
      if (insert) s_ctrl <= s_ctrl + idx_one;
      if (set_err) frame_err <= 1'b1;
      case ({insert, out_valid})
        2'b10:   flight <= flight + flight_one;
        2'b01:   flight <= flight - flight_one;
        default: flight <= flight;
      endcase
    end
  end

  // Flag delay line tracking the data path; drain zeros enter as invalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < pipe_latency; i++) vline[i] <= '0;
    end else if (enable) begin
      vline[0] <= {insert,
                   insert && (s_ctrl == idx_first),
                   insert && (s_ctrl == idx_last)};
      for (int i = 1; i < pipe_latency; i++) vline[i] <= vline[i-1];
    end
  end

  // Twiddle address follows s_ctrl through the multiplier-stage depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < tw_depth; i++) tw_line[i] <= '0;
    end else if (enable) begin
      tw_line[0] <= s_ctrl;
      for (int i = 1; i < tw_depth; i++) tw_line[i] <= tw_line[i-1];
    end
  end

endmodule
